gray_pos_decoder: RTL and testbench

Sequential Gray-to-binary decoder and position tracker: the receive end of the team's binary-to-Gray encoder.
- Samples a Gray-coded position word (encoder pointer, rotary/shaft encoder bus) on a valid strobe.
- Decodes it to binary and classifies each sample against the previous one as up-step, down-step, hold or illegal jump.
- Keeps a running signed position count.
- Sits between a Gray-coded source and control logic that needs binary position plus step events.

---
 rtl/gray_pos_decoder.sv | 118 +++++++++++
 tb/tb_gray_pos_decoder.sv | 114 +++++++++++
 2 files changed

// File: rtl/gray_pos_decoder.sv
// gray_pos_decoder: Gray-to-binary decoder with step classification and signed position tracking
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high, highest priority
//   in_valid   gray_in is sampled on this edge when high
//   gray_in    Gray-coded position word (W bits)
//   clr_err    clears err_sticky; a same-cycle step error wins
//   out_valid  one-cycle pulse: bin_out and flags updated
//   bin_out    binary value of the last accepted sample
//   dir_up     pulse: sample = previous + 1 (mod 2^W)
//   dir_down   pulse: sample = previous - 1 (mod 2^W)
//   step_err   pulse: sample moved by more than one step
//   err_sticky latched OR of step_err since reset or clear
//   pos_count  signed two's-complement running position (CNT_W bits)
//
// Build option SYNC2_EN: gray_in and in_valid pass through two-flop
// synchronizers first, adding two edges of latency.
module gray_pos_decoder #(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     gray_in,
    input  logic             clr_err,
    output logic             out_valid,
    output logic [W-1:0]     bin_out,
    output logic             dir_up,
    output logic             dir_down,
    output logic             step_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] pos_count
);
    typedef enum logic {IDLE, TRACK} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_valid;
    logic [W-1:0]       w_gray;
    logic [W-1:0]       w_bin;
    logic [W-1:0]       w_diff;
    logic [W-1:0]       r_prev;
    logic               w_track;
    logic               w_up;
    logic               w_down;
    logic               w_err;
    logic [CNT_W-1:0]   w_pos_nxt;

`ifdef SYNC2_EN
    logic [1:0]   r_v_sync;
    logic [W-1:0] r_g_s1;
    logic [W-1:0] r_g_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_sync <= '0;
            r_g_s1   <= '0;
            r_g_s2   <= '0;
        end else begin
            r_v_sync <= {r_v_sync[0], in_valid};
            r_g_s1   <= gray_in;
            r_g_s2   <= r_g_s1;
        end
    end

    assign w_valid = r_v_sync[1];
    assign w_gray  = r_g_s2;
`else
    assign w_valid = in_valid;
    assign w_gray  = gray_in;
`endif

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < W; i++) w_bin[i] = ^(w_gray >> i);
    end

    // Modular difference makes the 2^W-1 <-> 0 wrap a single step.
    assign w_diff = w_bin - r_prev;

    always_comb begin
        w_state_nxt = w_valid ? TRACK : r_state;
        w_track     = w_valid && (r_state == TRACK);
        w_up        = w_track && (w_diff == W'(1));
        w_down      = w_track && (w_diff == '1) && !w_up;
        w_err       = w_track && (w_diff != '0) && !w_up && !w_down;
        w_pos_nxt   = w_up ? pos_count + CNT_W'(1) : w_down ? pos_count - CNT_W'(1) : pos_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_prev     <= '0;
            out_valid  <= 1'b0;
            bin_out    <= '0;
            dir_up     <= 1'b0;
            dir_down   <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
            pos_count  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            out_valid  <= w_valid;
            dir_up     <= w_up;
            dir_down   <= w_down;
            step_err   <= w_err;
            err_sticky <= w_err | (err_sticky & ~clr_err);
            pos_count  <= w_pos_nxt;
            if (w_valid) begin
                r_prev  <= w_bin;
                bin_out <= w_bin;
            end
        end
    end
endmodule

// File: tb/tb_gray_pos_decoder.sv
// tb_gray_pos_decoder: directed checks of decode, step classification, wrap, errors and reset
module tb_gray_pos_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  gray_in = '0;
    logic        clr_err = 1'b0;
    logic        out_valid;
    logic [3:0]  bin_out;
    logic        dir_up;
    logic        dir_down;
    logic        step_err;
    logic        err_sticky;
    logic [15:0] pos_count;
    int          checks = 0;
    int          failures = 0;

    gray_pos_decoder #(.W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in), .clr_err(clr_err),
        .out_valid(out_valid), .bin_out(bin_out), .dir_up(dir_up), .dir_down(dir_down),
        .step_err(step_err), .err_sticky(err_sticky), .pos_count(pos_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int ov, input int bin, input int up,
                              input int dn, input int er, input int st, input int pos);
        chk({tag, ".out_valid"}, int'(out_valid), ov);
        chk({tag, ".bin_out"}, int'(bin_out), bin);
        chk({tag, ".dir_up"}, int'(dir_up), up);
        chk({tag, ".dir_down"}, int'(dir_down), dn);
        chk({tag, ".step_err"}, int'(step_err), er);
        chk({tag, ".err_sticky"}, int'(err_sticky), st);
        chk({tag, ".pos_count"}, int'(pos_count), pos);
    endtask

    task automatic step(input logic [3:0] g, input logic c);
        in_valid = 1'b1;
        gray_in  = g;
        clr_err  = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef SYNC2_EN
        repeat (2) begin
            @(posedge clk); #1;
        end
`endif
        clr_err = 1'b0;
    endtask

    task automatic idle(input logic c);
        clr_err = c;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        expect_out("rst", 0, 0, 0, 0, 0, 0, 0);

        step(4'b0000, 0); expect_out("up0", 1, 0, 0, 0, 0, 0, 0);
        step(4'b0001, 0); expect_out("up1", 1, 1, 1, 0, 0, 0, 1);
        step(4'b0011, 0); expect_out("up2", 1, 2, 1, 0, 0, 0, 2);
        step(4'b0010, 0); expect_out("up3", 1, 3, 1, 0, 0, 0, 3);
        step(4'b0011, 0); expect_out("dn2", 1, 2, 0, 1, 0, 0, 2);
        step(4'b0001, 0); expect_out("dn1", 1, 1, 0, 1, 0, 0, 1);
        step(4'b0011, 0); expect_out("re2", 1, 2, 1, 0, 0, 0, 2);
        step(4'b0010, 0); expect_out("re3", 1, 3, 1, 0, 0, 0, 3);

        for (int k = 0; k < 3; k++) begin
            idle(0);
            expect_out("gap", 0, 3, 0, 0, 0, 0, 3);
        end
        step(4'b0010, 0); expect_out("hold", 1, 3, 0, 0, 0, 0, 3);

        do_reset();
        expect_out("midrst", 0, 0, 0, 0, 0, 0, 0);
        step(4'b0110, 0); expect_out("base4", 1, 4, 0, 0, 0, 0, 0);
        step(4'b0111, 0); expect_out("up5", 1, 5, 1, 0, 0, 0, 1);

        do_reset();
        step(4'b1000, 0); expect_out("wbase", 1, 15, 0, 0, 0, 0, 0);
        step(4'b0000, 0); expect_out("wup", 1, 0, 1, 0, 0, 0, 1);
        step(4'b1000, 0); expect_out("wdn", 1, 15, 0, 1, 0, 0, 0);
        step(4'b1001, 0); expect_out("posneg", 1, 14, 0, 1, 0, 0, 16'hFFFF);
        step(4'b1000, 0); expect_out("posup", 1, 15, 1, 0, 0, 0, 0);

        do_reset();
        step(4'b0000, 0); expect_out("ebase", 1, 0, 0, 0, 0, 0, 0);
        step(4'b0011, 0); expect_out("jump", 1, 2, 0, 0, 1, 1, 0);
        step(4'b0010, 0); expect_out("afterj", 1, 3, 1, 0, 0, 1, 1);
        idle(1);          expect_out("clr", 0, 3, 0, 0, 0, 0, 1);
        step(4'b0000, 1); expect_out("clrset", 1, 0, 0, 0, 1, 1, 1);
        idle(0);          expect_out("keep", 0, 0, 0, 0, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
